// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage.
// Holds the occupancy encoding and default widths.
package pipe_pkg;

    localparam int PAYLOAD_W_DEF = 71;
    localparam int CNT_W_DEF     = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Sticks at all-ones; only reset clears it.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc until every bit is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage.
// in_ready is registered so no combinational path crosses the stage.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_count
);

    state_t               state;
    state_t               state_nx;
    logic [PAYLOAD_W-1:0] main;
    logic [PAYLOAD_W-1:0] main_nx;
    logic [PAYLOAD_W-1:0] skid;
    logic [PAYLOAD_W-1:0] skid_nx;
    logic                 ready_q;
    logic                 push;
    logic                 pop;

    assign in_ready  = ready_q;
    assign out_valid = (state != EMPTY);
    assign out_data  = main;
    assign occupancy = state;

    assign push = in_valid & ready_q;
    assign pop  = out_valid & out_ready;

    // Next occupancy and payload moves; vacated slots are zeroed.
    always_comb begin
        state_nx = state;
        main_nx  = main;
        skid_nx  = skid;
        if (flush) begin
            state_nx = EMPTY;
            main_nx  = '0;
            skid_nx  = '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        main_nx  = in_data;
                        state_nx = BUSY;
                    end
                end
                BUSY: begin
                    if (push && pop) begin
                        main_nx = in_data;
                    end else if (pop) begin
                        main_nx  = '0;
                        state_nx = EMPTY;
                    end else if (push) begin
                        skid_nx  = in_data;
                        state_nx = FULL;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_nx  = skid;
                        skid_nx  = '0;
                        state_nx = BUSY;
                    end
                end
                default: begin
                    state_nx = EMPTY;
                    main_nx  = '0;
                    skid_nx  = '0;
                end
            endcase
        end
    end

    // State, payload and registered ready update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            main    <= '0;
            skid    <= '0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nx;
            main    <= main_nx;
            skid    <= skid_nx;
            ready_q <= (state_nx != FULL);
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_valid & ~out_ready),
        .count(stall_count)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks for pipe_stage_skid.
// A small CNT_W=4 instance shares the stimulus for the saturation case.
module tb_pipe_stage_skid;

    localparam int PW = 71;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [PW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_count;

    logic          in_ready4;
    logic          out_valid4;
    logic [PW-1:0] out_data4;
    logic [1:0]    occupancy4;
    logic [3:0]    stall_count4;

    int tests = 0;
    int fails = 0;

    pipe_stage_skid dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .stall_count(stall_count)
    );

    pipe_stage_skid #(.PAYLOAD_W(PW), .CNT_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready4),
        .in_data    (in_data),
        .out_valid  (out_valid4),
        .out_ready  (out_ready),
        .out_data   (out_data4),
        .occupancy  (occupancy4),
        .stall_count(stall_count4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = PW'(71'h5a5a);
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        tests++;
        if ({in_ready, out_valid, occupancy} !== 4'b1000 ||
            out_data !== '0 || stall_count !== 16'd0) begin
            fails++;
            $display("FAIL reset: rdy=%b vld=%b occ=%0d data=%h cnt=%0d want 1 0 0 0 0",
                     in_ready, out_valid, occupancy, out_data, stall_count);
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data = PW'(i);
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_data !== PW'(i) || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL stream[%0d]: vld=%b data=%h rdy=%b want 1 %h 1",
                         i, out_valid, out_data, in_ready, PW'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL stream_drain: vld=%b data=%h occ=%0d want 0 0 0",
                     out_valid, out_data, occupancy);
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] a = PW'(71'hA);
        logic [PW-1:0] b = PW'(71'hB);
        logic [PW-1:0] c = PW'(71'hC);
        do_reset();
        in_valid = 1'b1;
        in_data = a;
        tick();
        tests++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== a) begin
            fails++;
            $display("FAIL bp_a: occ=%0d rdy=%b data=%h want 1 1 %h",
                     occupancy, in_ready, out_data, a);
        end
        in_data = b;
        tick();
        tests++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== a) begin
            fails++;
            $display("FAIL bp_b: occ=%0d rdy=%b data=%h want 2 0 %h",
                     occupancy, in_ready, out_data, a);
        end
        in_data = c;
        tick();
        tests++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== a ||
            stall_count !== 16'd2) begin
            fails++;
            $display("FAIL bp_c_held: occ=%0d rdy=%b data=%h cnt=%0d want 2 0 %h 2",
                     occupancy, in_ready, out_data, stall_count, a);
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_data !== b || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_out_b: data=%h occ=%0d rdy=%b want %h 1 1",
                     out_data, occupancy, in_ready, b);
        end
        tick();
        tests++;
        if (out_data !== c || occupancy !== 2'd1) begin
            fails++;
            $display("FAIL bp_out_c: data=%h occ=%0d want %h 1", out_data, occupancy, c);
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b0 || stall_count !== 16'd2) begin
            fails++;
            $display("FAIL bp_end: vld=%b cnt=%0d want 0 2", out_valid, stall_count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1;
        in_data = PW'(71'h11);
        tick();
        in_data = PW'(71'h22);
        tick();
        in_data = PW'(71'h33);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== '0 ||
            dut.skid !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush: occ=%0d vld=%b data=%h skid=%h rdy=%b want 0 0 0 0 1",
                     occupancy, out_valid, out_data, dut.skid, in_ready);
        end
        tests++;
        if (stall_count !== 16'd2) begin
            fails++;
            $display("FAIL flush_cnt: cnt=%0d want 2", stall_count);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL flush_absent: vld=%b occ=%0d want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1;
        in_data = PW'(71'h5);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        tests++;
        if (stall_count4 !== 4'd15 || stall_count !== 16'd20 || out_data4 !== PW'(71'h5)) begin
            fails++;
            $display("FAIL sat: cnt4=%0d cnt16=%0d data=%h want 15 20 5",
                     stall_count4, stall_count, out_data4);
        end
        tick();
        tests++;
        if (stall_count4 !== 4'd15) begin
            fails++;
            $display("FAIL sat_hold: cnt4=%0d want 15", stall_count4);
        end
    endtask

    task automatic test_reset_full();
        do_reset();
        in_valid = 1'b1;
        in_data = PW'(71'h44);
        tick();
        in_data = PW'(71'h55);
        tick();
        tick();
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        tests++;
        if ({in_ready, out_valid, occupancy} !== 4'b1000 || out_data !== '0 ||
            stall_count !== 16'd0 || stall_count4 !== 4'd0) begin
            fails++;
            $display("FAIL reset_full: rdy=%b vld=%b occ=%0d data=%h cnt=%0d want 1 0 0 0 0",
                     in_ready, out_valid, occupancy, out_data, stall_count);
        end
    endtask

    task automatic test_random();
        logic [PW-1:0] q[$];
        logic [PW-1:0] exp_data;
        int            mcnt;
        logic          psh;
        logic          pp;
        do_reset();
        mcnt = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            exp_data = (q.size() != 0) ? q[0] : '0;
            tests++;
            if (out_valid !== (q.size() != 0) || out_data !== exp_data ||
                occupancy !== 2'(q.size()) || in_ready !== (q.size() < 2) ||
                stall_count !== 16'(mcnt)) begin
                fails++;
                $display("FAIL random[%0d]: vld=%b data=%h occ=%0d rdy=%b cnt=%0d want data=%h occ=%0d cnt=%0d",
                         cyc, out_valid, out_data, occupancy, in_ready, stall_count,
                         exp_data, q.size(), mcnt);
            end
            in_valid = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 31) == 0);
            in_data = {7'($urandom), $urandom, $urandom};
            psh = in_valid && (q.size() < 2);
            pp = (q.size() != 0) && out_ready;
            if ((q.size() != 0) && !out_ready && mcnt < 65535) mcnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (pp) void'(q.pop_front());
                if (psh) q.push_back(in_data);
            end
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturation();
        test_reset_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
